// File: rtl/rv_core_pkg.sv
// Shared RV32 core constants: datapath defaults and decoded control-bundle bit positions.
package rv_core_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 16;

  // Positions inside the decoded control bundle carried down the pipe
  localparam int CTRL_REGWRITE      = 0;
  localparam int CTRL_MEMWRITE      = 1;
  localparam int CTRL_MEMREAD       = 2;
  localparam int CTRL_BRANCH        = 3;
  localparam int CTRL_JUMP          = 4;
  localparam int CTRL_ALUSRC        = 5;
  localparam int CTRL_ALUCTRL_LSB   = 6;
  localparam int CTRL_ALUCTRL_MSB   = 9;
  localparam int CTRL_RESULTSRC_LSB = 10;
  localparam int CTRL_RESULTSRC_MSB = 11;

  // rd1, rd2, pc, pcplus4, imm
  localparam int NUM_DATA_FIELDS = 5;
endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module sat_counter
  import rv_core_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register with valid/ready handshake, flush, and stall/bubble counters.
module id_ex_pipe_reg
  import rv_core_pkg::*;
#(
  parameter int XLEN   = rv_core_pkg::XLEN,
  parameter int REG_AW = rv_core_pkg::REG_AW,
  parameter int CTRL_W = rv_core_pkg::CTRL_W,
  parameter int CNT_W  = rv_core_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pcplus4_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pcplus4_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  localparam int DATA_W = NUM_DATA_FIELDS * XLEN;
  localparam int KILL_W = CTRL_W + 3 * REG_AW;

  // Data fields survive a kill; the kill group is zeroed so an empty slot never writes back or forwards.
  logic [DATA_W-1:0] data_q, data_d;
  logic [KILL_W-1:0] kill_q, kill_d;
  logic              ex_valid_q, ex_valid_d;
  logic              load, consume;

  assign id_ready_o = flush_i | ~ex_valid_q | ex_ready_i;
  assign load       = id_valid_i & id_ready_o & ~flush_i;
  assign consume    = ex_valid_q & ex_ready_i;

  always_comb begin
    ex_valid_d = ex_valid_q;
    data_d     = data_q;
    kill_d     = kill_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      kill_d     = '0;
    end else if (load) begin
      ex_valid_d = 1'b1;
      data_d     = {rd1_d, rd2_d, pc_d, pcplus4_d, imm_d};
      kill_d     = {ctrl_d, rd_d, rs1_d, rs2_d};
    end else if (consume) begin
      ex_valid_d = 1'b0;
      kill_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      data_q     <= '0;
      kill_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      data_q     <= data_d;
      kill_q     <= kill_d;
    end
  end

  assign ex_valid_o = ex_valid_q;
  assign {rd1_e, rd2_e, pc_e, pcplus4_e, imm_e} = data_q;
  assign {ctrl_e, rd_e, rs1_e, rs2_e}           = kill_q;

  // Both counters look at the pre-edge handshake state
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_valid_q & ~ex_ready_i),
    .cnt   (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~ex_valid_q),
    .cnt   (bubble_cnt_o)
  );
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: directed scenarios plus random traffic against a cycle-level reference model.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 32, REG_AW = 5, CTRL_W = 16, CNT_W = 16, SCNT_W = 4;
  localparam int VW = 1 + 5*XLEN + 3*REG_AW + CTRL_W + 2*CNT_W;

  logic clk = 1'b0, reset = 1'b1, flush_i = 1'b0, id_valid_i = 1'b0, ex_ready_i = 1'b0;
  logic [XLEN-1:0] rd1_d = '0, rd2_d = '0, pc_d = '0, pcplus4_d = '0, imm_d = '0;
  logic [REG_AW-1:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic [CTRL_W-1:0] ctrl_d = '0;

  logic id_ready_o, ex_valid_o, s_id_ready, s_ex_valid;
  logic [XLEN-1:0] rd1_e, rd2_e, pc_e, pcplus4_e, imm_e;
  logic [XLEN-1:0] s_rd1, s_rd2, s_pc, s_pc4, s_imm;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e, s_rs1, s_rs2, s_rd;
  logic [CTRL_W-1:0] ctrl_e, s_ctrl;
  logic [CNT_W-1:0] stall_cnt_o, bubble_cnt_o;
  logic [SCNT_W-1:0] s_stall, s_bubble;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .imm_d(imm_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .ctrl_d(ctrl_d),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .pcplus4_e(pcplus4_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .ctrl_e(ctrl_e),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o));

  // Narrow-counter copy sees identical stimulus; used for saturation checks
  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W), .CNT_W(SCNT_W)) u_sat (
    .clk(clk), .reset(reset), .flush_i(flush_i), .id_valid_i(id_valid_i), .id_ready_o(s_id_ready),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d), .imm_d(imm_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .ctrl_d(ctrl_d),
    .ex_valid_o(s_ex_valid), .ex_ready_i(ex_ready_i),
    .rd1_e(s_rd1), .rd2_e(s_rd2), .pc_e(s_pc), .pcplus4_e(s_pc4), .imm_e(s_imm),
    .rs1_e(s_rs1), .rs2_e(s_rs2), .rd_e(s_rd), .ctrl_e(s_ctrl),
    .stall_cnt_o(s_stall), .bubble_cnt_o(s_bubble));

  int n_vec = 0, n_err = 0;

  // Reference model: one EX slot plus plain integer cycle counts
  bit m_valid;
  logic [XLEN-1:0] m_rd1, m_rd2, m_pc, m_pc4, m_imm;
  logic [REG_AW-1:0] m_rs1, m_rs2, m_rd;
  logic [CTRL_W-1:0] m_ctrl;
  int m_stall, m_bubble;

  wire [VW-1:0] act_vec = {ex_valid_o, rd1_e, rd2_e, pc_e, pcplus4_e, imm_e,
                           rs1_e, rs2_e, rd_e, ctrl_e, stall_cnt_o, bubble_cnt_o};

  function automatic logic [CNT_W-1:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[CNT_W-1:0];
  endfunction

  function automatic logic [SCNT_W-1:0] sat4(input int v);
    return (v > 15) ? 4'hF : v[SCNT_W-1:0];
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_rd1, m_rd2, m_pc, m_pc4, m_imm, m_rs1, m_rs2, m_rd, m_ctrl,
            sat16(m_stall), sat16(m_bubble)};
  endfunction

  function automatic bit exp_ready();
    return flush_i || !m_valid || ex_ready_i;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rd1 = '0; m_rd2 = '0; m_pc = '0; m_pc4 = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_stall = 0; m_bubble = 0;
  endtask

  task automatic model_edge();
    bit take;
    take = id_valid_i && !flush_i && (!m_valid || ex_ready_i);
    if (m_valid && !ex_ready_i) m_stall++;
    if (!m_valid) m_bubble++;
    if (flush_i || (!take && m_valid && ex_ready_i)) begin
      m_valid = 0; m_ctrl = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    end else if (take) begin
      m_valid = 1; m_rd1 = rd1_d; m_rd2 = rd2_d; m_pc = pc_d; m_pc4 = pcplus4_d; m_imm = imm_d;
      m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d; m_ctrl = ctrl_d;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic rand_payload();
    rd1_d = $urandom; rd2_d = $urandom; pc_d = $urandom; imm_d = $urandom;
    pcplus4_d = pc_d + 32'd4;
    rs1_d = REG_AW'($urandom); rs2_d = REG_AW'($urandom); rd_d = REG_AW'($urandom);
    ctrl_d = CTRL_W'($urandom) | CTRL_W'(1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (act_vec !== '0 || id_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_hold: outputs=%h id_ready=%b, required all 0 and id_ready=1", act_vec, id_ready_o);
    end
    reset = 0; model_reset();
    for (int i = 0; i < 6; i++) begin
      rand_payload(); id_valid_i = 1; ex_ready_i = (i % 3) != 2; tick();
    end
    #2 reset = 1;
    #1 n_vec++;
    if (act_vec !== '0 || s_stall !== '0 || s_bubble !== '0) begin
      n_err++; $display("FAIL reset_async: outputs=%h, required all 0 immediately", act_vec);
    end
    model_reset();
    @(negedge clk);
    reset = 0; id_valid_i = 0; ex_ready_i = 0;
    #1 n_vec++;
    if (act_vec !== '0 || id_ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_release: outputs=%h id_ready=%b, required 0 and 1", act_vec, id_ready_o);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 4; i++) begin
      rand_payload(); pc_d = 32'h100 + 32'(4*i); pcplus4_d = pc_d + 32'd4;
      id_valid_i = 1; ex_ready_i = 1;
      tick();
      n_vec++;
      if (act_vec !== exp_vec() || pc_e !== 32'h100 + 32'(4*i) || ex_valid_o !== 1'b1 || stall_cnt_o !== '0) begin
        n_err++; $display("FAIL stream[%0d]: pc_e=%h valid=%b stall=%0d, required pc_e=%h valid=1 stall=0",
                          i, pc_e, ex_valid_o, stall_cnt_o, 32'h100 + 32'(4*i));
      end
    end
  endtask

  task automatic test_stall();
    rand_payload(); pc_d = 32'h200; pcplus4_d = 32'h204; rd_d = 5;
    id_valid_i = 1; ex_ready_i = 1; tick();
    for (int i = 0; i < 3; i++) begin
      rand_payload(); ex_ready_i = 0;
      #1 n_vec++;
      if (id_ready_o !== 1'b0) begin
        n_err++; $display("FAIL stall_ready[%0d]: id_ready=%b, required 0", i, id_ready_o);
      end
      tick();
    end
    n_vec++;
    if (act_vec !== exp_vec() || pc_e !== 32'h200 || rd_e !== 5'd5 || stall_cnt_o !== 16'd3) begin
      n_err++; $display("FAIL stall_hold: pc_e=%h rd_e=%0d stall=%0d, required 200 5 3", pc_e, rd_e, stall_cnt_o);
    end
  endtask

  task automatic test_flush();
    int b0;
    rand_payload(); flush_i = 1; id_valid_i = 1; ex_ready_i = 0;
    #1 n_vec++;
    if (id_ready_o !== 1'b1) begin
      n_err++; $display("FAIL flush_ready: id_ready=%b, required 1", id_ready_o);
    end
    tick();
    flush_i = 0; id_valid_i = 0;
    n_vec++;
    if (act_vec !== exp_vec() || ex_valid_o !== 1'b0 || ctrl_e !== '0 || rd_e !== '0 || pc_e !== 32'h200) begin
      n_err++; $display("FAIL flush: valid=%b ctrl=%h rd=%0d pc_e=%h, required 0 0 0 200", ex_valid_o, ctrl_e, rd_e, pc_e);
    end
    b0 = int'(bubble_cnt_o);
    tick();
    n_vec++;
    if (int'(bubble_cnt_o) !== b0 + 1 || act_vec !== exp_vec()) begin
      n_err++; $display("FAIL flush_bubble: bubble=%0d, required %0d", bubble_cnt_o, b0 + 1);
    end
  endtask

  task automatic test_drain();
    logic [XLEN-1:0] r1;
    rand_payload(); id_valid_i = 1; ex_ready_i = 0; tick();
    r1 = rd1_e;
    rand_payload(); id_valid_i = 0; ex_ready_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (act_vec !== exp_vec() || ex_valid_o !== 1'b0 || ctrl_e !== '0 || rd_e !== '0 || rd1_e !== r1) begin
        n_err++; $display("FAIL drain[%0d]: valid=%b ctrl=%h rd=%0d rd1_e=%h, required 0 0 0 %h",
                          i, ex_valid_o, ctrl_e, rd_e, rd1_e, r1);
      end
    end
  endtask

  task automatic test_saturation();
    rand_payload(); id_valid_i = 1; ex_ready_i = 1; tick();
    ex_ready_i = 0;
    repeat (20) begin rand_payload(); tick(); end
    n_vec++;
    if (s_stall !== 4'd15 || s_bubble !== sat4(m_bubble)) begin
      n_err++; $display("FAIL sat_stall: stall=%0d bubble=%0d, required 15 %0d", s_stall, s_bubble, sat4(m_bubble));
    end
    n_vec++;
    if (act_vec !== exp_vec()) begin
      n_err++; $display("FAIL sat_wide: stall=%0d, required %0d", stall_cnt_o, sat16(m_stall));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_payload();
      flush_i    = ($urandom_range(0, 7) == 0);
      id_valid_i = ($urandom_range(0, 3) != 0);
      ex_ready_i = $urandom_range(0, 1) == 1;
      #1 n_vec++;
      if (id_ready_o !== exp_ready()) begin
        n_err++; $display("FAIL rand_ready[%0d]: id_ready=%b, required %b", i, id_ready_o, exp_ready());
      end
      tick();
      n_vec++;
      if (act_vec !== exp_vec() || s_stall !== sat4(m_stall) || s_bubble !== sat4(m_bubble)) begin
        n_err++; $display("FAIL rand_out[%0d]: got %h, required %h", i, act_vec, exp_vec());
      end
      n_vec++;
      if (!ex_valid_o && (ctrl_e !== '0 || rd_e !== '0)) begin
        n_err++; $display("FAIL rand_inv[%0d]: ctrl=%h rd=%0d with valid=0, required 0 0", i, ctrl_e, rd_e);
      end
    end
    flush_i = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_drain();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
